alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Sequences operations into the combinational ALU (alu_pkg in_t / control_e / status_t) for the execute stage.
- Registers operands and opcode, holds them stable for multi-cycle MULT/DIV settling, captures result and flags, and returns them over a valid/ready response port.
- Replaces the ALU's divide-by-zero simulation assert with an architected error response; the divider is never driven with b == 0.

Parameters:
- MULT_LAT, 2, cycles operands are held before capturing a MULT result (>=1)
- DIV_LAT, 4, cycles operands are held before capturing a DIV result (>=1)

Ports:
- clk  input  1  single clock; all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  sequencer can accept a request this cycle
- req_op  input  alu_pkg::control_e  operation
- req_a  input  16  operand a
- req_b  input  16  operand b
- alu_in  output  alu_pkg::in_t  registered operands to ALU
- alu_control  output  alu_pkg::control_e  registered opcode to ALU
- alu_out  input  32  ALU result
- alu_stat  input  alu_pkg::status_t  ALU zero/overflow/sign
- rsp_valid  output  1  response held
- rsp_ready  input  1  consumer takes response
- rsp_result  output  32  captured result (DIV: [15:0] quotient, [31:16] remainder)
- rsp_stat  output  alu_pkg::status_t  captured flags
- rsp_div_zero  output  1  DIV with b == 0; result forced 0
- busy  output  1  state != IDLE

Behaviour:
- Reset (async assert, sync-deassert-safe): state=IDLE; alu_in=0; alu_control=ADD; rsp_valid=0; rsp_result=0; rsp_stat=0; rsp_div_zero=0; count=0; busy=0. Reset mid-operation discards the in-flight op with no response.
- States: IDLE, EXEC, RESP.
- req_ready = (state==IDLE) | (state==RESP & rsp_ready). Transfer = req_valid & req_ready.
- On transfer: latch req_a/req_b into alu_in, req_op into alu_control; count loaded with MULT_LAT-1 for MULT, DIV_LAT-1 for DIV, 0 otherwise; go to EXEC.
- DIV with req_b==0: alu_control is loaded with ADD (divider never sees b==0); op is flagged div_zero internally; count=0.
- EXEC: if count!=0, decrement and stay. If count==0: capture rsp_result=alu_out, rsp_stat=alu_stat (div_zero: rsp_result=0, rsp_stat={zero=1,overflow=0,sign=0}, rsp_div_zero=1); set rsp_valid; go to RESP.
- Latency, transfer edge to rsp_valid high: 1 cycle for single-cycle ops, MULT_LAT for MULT, DIV_LAT for DIV and DIV-by-zero 1 cycle.
- RESP: rsp_valid and all rsp_* stable until rsp_valid & rsp_ready.
  - rsp_ready without a new request: clear rsp_valid and rsp_div_zero; go to IDLE.
  - rsp_ready with a new request (back-to-back): accept it in the same cycle; go to EXEC; rsp_valid drops for at least one cycle.
- alu_in and alu_control change only on transfer; they hold their last values in IDLE and RESP.
- Throughput: at most one op per 2 cycles; one op in flight.
- req_op / req_a / req_b are ignored when no transfer occurs.

Test Plan:
- ADD a=0x7FFF b=0x0001, rsp_ready=1 -> rsp_valid 1 cycle after accept; rsp_result=0x00008000; stat.overflow=1, sign=1, zero=0.
- MULT a=0x0100 b=0x0100, MULT_LAT=2 -> rsp_valid 2 cycles after accept; rsp_result=0x00010000; sign=0; zero=0.
- DIV a=17 b=5, DIV_LAT=4 -> rsp_valid 4 cycles after accept; rsp_result=0x00020003; alu_control stays DIV during EXEC.
- DIV a=9 b=0 -> rsp_valid after 1 cycle; rsp_result=0; rsp_div_zero=1; stat.zero=1; alu_control observed as ADD, never DIV.
- Backpressure plus back-to-back:
  - SUB 5-5 with rsp_ready=0 for 3 cycles -> rsp_result=0, zero=1 held stable and req_ready=0.
  - Then raise rsp_ready with req_valid=1 (OR 0x00F0|0x000F) -> second op accepted in the same cycle; next response rsp_result=0x000000FF.
- Assert rst_n=0 mid-DIV (count=2) -> rsp_valid=0, busy=0, alu_in=0 immediately (async); after release, req_ready=1 and no stale response appears.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the execute-stage ALU and the blocks that drive it.
package alu_pkg;

    typedef enum logic [2:0] {
        ADD  = 3'd0,
        SUB  = 3'd1,
        MULT = 3'd2,
        DIV  = 3'd3,
        AND  = 3'd4,
        OR   = 3'd5,
        XOR  = 3'd6,
        NOR  = 3'd7
    } control_e;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
    } in_t;

    typedef struct packed {
        logic zero;
        logic overflow;
        logic sign;
    } status_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request/response handshake between a requester and alu_op_sequencer.
interface alu_op_sequencer_if;
    import alu_pkg::*;

    logic        req_valid;
    logic        req_ready;
    control_e    req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    status_t     rsp_stat;
    logic        rsp_div_zero;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_stat, rsp_div_zero
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_stat, rsp_div_zero
    );

endinterface

// File: rtl/alu_op_sequencer.sv
// Holds operands stable at the combinational ALU for as many cycles as the
// selected operation needs to settle, then returns result and flags over a
// valid/ready response. Divide-by-zero never reaches the divider; it is
// answered with an architected error response instead.
module alu_op_sequencer #(
    parameter int MULT_LAT = 2,
    parameter int DIV_LAT  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_op_sequencer_if.slave   bus,
    output alu_pkg::in_t        alu_in,
    output alu_pkg::control_e   alu_control,
    input  logic [31:0]         alu_out,
    input  alu_pkg::status_t    alu_stat,
    output logic                busy
);
    import alu_pkg::*;

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e             state;
    state_e             state_next;
    logic               transfer;
    logic               capture;
    logic               div_zero_op;
    logic [CNT_W-1:0]   count;

    // State register.
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next state, request acceptance and result-capture strobe.
    // NOTE: every output of this block is defaulted first so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_next    = state;
        bus.req_ready = 1'b0;
        capture       = 1'b0;
        case (state)
            IDLE: bus.req_ready = 1'b1;
            EXEC: begin
                if (count == '0) begin
                    capture    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                // Back-to-back: a consumed response frees the slot this cycle.
                bus.req_ready = bus.rsp_ready;
                if (bus.rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        transfer = bus.req_valid & bus.req_ready;
        if (transfer) state_next = EXEC;
    end

    assign busy = (state != IDLE);

    // Operand/opcode registers and settle counter; operands move only on transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_in      <= '0;
            alu_control <= ADD;
            count       <= '0;
            div_zero_op <= 1'b0;
        end else if (transfer) begin
            alu_in.a <= bus.req_a;
            alu_in.b <= bus.req_b;
            if (bus.req_op == DIV && bus.req_b == 16'd0) begin
                // Park the ALU on a harmless op; the answer is architected.
                alu_control <= ADD;
                div_zero_op <= 1'b1;
                count       <= '0;
            end else begin
                alu_control <= bus.req_op;
                div_zero_op <= 1'b0;
                case (bus.req_op)
                    MULT:    count <= CNT_W'(MULT_LAT - 1);
                    DIV:     count <= CNT_W'(DIV_LAT - 1);
                    default: count <= '0;
                endcase
            end
        end else if (state == EXEC && count != '0) begin
            count <= count - 1'b1;
        end
    end

    // Response registers; held stable until the consumer takes them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rsp_valid    <= 1'b0;
            bus.rsp_result   <= '0;
            bus.rsp_stat     <= '0;
            bus.rsp_div_zero <= 1'b0;
        end else if (capture) begin
            bus.rsp_valid <= 1'b1;
            if (div_zero_op) begin
                bus.rsp_result   <= '0;
                bus.rsp_stat     <= '{zero: 1'b1, overflow: 1'b0, sign: 1'b0};
                bus.rsp_div_zero <= 1'b1;
            end else begin
                bus.rsp_result   <= alu_out;
                bus.rsp_stat     <= alu_stat;
                bus.rsp_div_zero <= 1'b0;
            end
        end else if (bus.rsp_valid && bus.rsp_ready) begin
            bus.rsp_valid    <= 1'b0;
            bus.rsp_div_zero <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed and randomized checks of alu_op_sequencer against a behavioural
// model of the ALU operations and of the expected response timing.
module tb_alu_op_sequencer;
    import alu_pkg::*;

    localparam int MULT_LAT = 2;
    localparam int DIV_LAT  = 4;

    typedef struct packed {
        status_t     stat;
        logic [31:0] result;
    } ref_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    in_t         alu_in;
    control_e    alu_control;
    logic [31:0] alu_out;
    status_t     alu_stat;
    logic        busy;
    logic        div_zero_exposed = 1'b0;

    int errors = 0;
    int checks = 0;

    alu_op_sequencer_if bus();

    alu_op_sequencer #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .alu_in     (alu_in),
        .alu_control(alu_control),
        .alu_out    (alu_out),
        .alu_stat   (alu_stat),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Reference semantics of each operation on 16-bit operands.
    function automatic ref_t alu_ref(control_e op, logic [15:0] a, logic [15:0] b);
        ref_t        r;
        logic [15:0] r16;
        r = '0;
        case (op)
            ADD: begin
                r16 = a + b;
                r.result = {16'd0, r16};
                r.stat.overflow = (a[15] == b[15]) && (r16[15] != a[15]);
            end
            SUB: begin
                r16 = a - b;
                r.result = {16'd0, r16};
                r.stat.overflow = (a[15] != b[15]) && (r16[15] != a[15]);
            end
            MULT: r.result = 32'(a) * 32'(b);
            DIV:  if (b != 0) r.result = {a % b, a / b};
            AND:  r.result = {16'd0, a & b};
            OR:   r.result = {16'd0, a | b};
            XOR:  r.result = {16'd0, a ^ b};
            NOR:  r.result = {16'd0, ~(a | b)};
            default: r.result = '0;
        endcase
        r.stat.zero = (r.result == 32'd0);
        r.stat.sign = (op == MULT || op == DIV) ? r.result[31] : r.result[15];
        return r;
    endfunction

    // Expected latency from transfer edge to rsp_valid.
    function automatic int exp_lat(control_e op, logic [15:0] b);
        if (op == MULT)           return MULT_LAT;
        if (op == DIV && b != 0)  return DIV_LAT;
        return 1;
    endfunction

    // Stand-in combinational ALU driven by the sequencer.
    always_comb begin
        {alu_stat, alu_out} = alu_ref(alu_control, alu_in.a, alu_in.b);
    end

    // Watch for the divider ever being presented with a zero divisor.
    always @(posedge clk) begin
        if (rst_n && alu_control == DIV && alu_in.b == 16'd0) div_zero_exposed <= 1'b1;
    end

    task automatic check(string tag, logic [31:0] observed, logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Present a request and return at the negedge after it is accepted.
    task automatic issue(control_e op, logic [15:0] a, logic [15:0] b);
        int n = 0;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_accept_timeout", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_op    = control_e'($urandom_range(0, 7));
        bus.req_a     = 16'($urandom);
        bus.req_b     = 16'($urandom);
    endtask

    // Count edges after the transfer edge until a response is present.
    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!bus.rsp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("rsp_valid_timeout", {31'd0, bus.rsp_valid}, 32'd1);
    endtask

    task automatic check_rsp(string tag, control_e op, logic [15:0] a, logic [15:0] b, int lat);
        ref_t exp;
        logic dz;
        dz  = (op == DIV && b == 16'd0);
        exp = dz ? ref_t'({3'b100, 32'd0}) : alu_ref(op, a, b);
        check({tag, "_lat"},    32'(lat), 32'(exp_lat(op, b)));
        check({tag, "_result"}, bus.rsp_result, exp.result);
        check({tag, "_stat"},   {29'd0, bus.rsp_stat}, {29'd0, exp.stat});
        check({tag, "_dz"},     {31'd0, bus.rsp_div_zero}, {31'd0, dz});
    endtask

    initial begin
        int       lat;
        int       hold;
        control_e op;
        logic [15:0] a, b;
        logic [31:0] held;
        logic        stale;

        bus.req_valid = 1'b0;
        bus.req_op    = ADD;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_busy",      {31'd0, busy}, 32'd0);
        check("rst_alu_in",    alu_in, 32'd0);
        check("rst_alu_ctrl",  32'(alu_control), 32'(ADD));
        check("rst_result",    bus.rsp_result, 32'd0);
        check("rst_stat",      {29'd0, bus.rsp_stat}, 32'd0);
        check("rst_dz",        {31'd0, bus.rsp_div_zero}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_req_ready", {31'd0, bus.req_ready}, 32'd1);

        // ADD with signed overflow.
        bus.rsp_ready = 1'b1;
        issue(ADD, 16'h7FFF, 16'h0001);
        wait_rsp(lat);
        check_rsp("add", ADD, 16'h7FFF, 16'h0001, lat);
        check("add_result_const", bus.rsp_result, 32'h0000_8000);
        @(negedge clk);
        check("add_consumed", {31'd0, bus.rsp_valid}, 32'd0);

        // MULT settles for MULT_LAT cycles.
        issue(MULT, 16'h0100, 16'h0100);
        wait_rsp(lat);
        check_rsp("mult", MULT, 16'h0100, 16'h0100, lat);
        check("mult_result_const", bus.rsp_result, 32'h0001_0000);
        @(negedge clk);

        // DIV holds its opcode while settling.
        issue(DIV, 16'd17, 16'd5);
        check("div_exec_ctrl", 32'(alu_control), 32'(DIV));
        check("div_exec_busy", {31'd0, busy}, 32'd1);
        wait_rsp(lat);
        check_rsp("div", DIV, 16'd17, 16'd5, lat);
        check("div_result_const", bus.rsp_result, 32'h0002_0003);
        @(negedge clk);

        // DIV by zero answered without touching the divider.
        issue(DIV, 16'd9, 16'd0);
        check("dz_exec_ctrl", 32'(alu_control), 32'(ADD));
        wait_rsp(lat);
        check_rsp("divz", DIV, 16'd9, 16'd0, lat);
        @(negedge clk);
        check("dz_cleared", {31'd0, bus.rsp_div_zero}, 32'd0);

        // Backpressure on a SUB response, then a back-to-back OR.
        bus.rsp_ready = 1'b0;
        issue(SUB, 16'd5, 16'd5);
        wait_rsp(lat);
        check_rsp("sub", SUB, 16'd5, 16'd5, lat);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_valid",  {31'd0, bus.rsp_valid}, 32'd1);
            check("bp_result", bus.rsp_result, 32'd0);
            check("bp_stat",   {29'd0, bus.rsp_stat}, 32'h4);
            check("bp_ready",  {31'd0, bus.req_ready}, 32'd0);
        end
        bus.req_valid = 1'b1;
        bus.req_op    = OR;
        bus.req_a     = 16'h00F0;
        bus.req_b     = 16'h000F;
        bus.rsp_ready = 1'b1;
        #1;
        check("b2b_req_ready", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("b2b_valid_gap", {31'd0, bus.rsp_valid}, 32'd0);
        check("b2b_busy",      {31'd0, busy}, 32'd1);
        wait_rsp(lat);
        check_rsp("or", OR, 16'h00F0, 16'h000F, lat);
        check("or_result_const", bus.rsp_result, 32'h0000_00FF);
        @(negedge clk);
        bus.rsp_ready = 1'b0;

        // Randomized operations with random response backpressure.
        for (int t = 0; t < 40; t++) begin
            op = control_e'($urandom_range(0, 7));
            a  = 16'($urandom);
            b  = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
            issue(op, a, b);
            wait_rsp(lat);
            check_rsp("rand", op, a, b, lat);
            held = bus.rsp_result;
            hold = $urandom_range(0, 2);
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                check("rand_hold", bus.rsp_result, held);
            end
            bus.rsp_ready = 1'b1;
            @(negedge clk);
            bus.rsp_ready = 1'b0;
            check("rand_consumed", {31'd0, bus.rsp_valid}, 32'd0);
        end

        // Reset in the middle of a DIV discards it.
        bus.rsp_ready = 1'b1;
        issue(DIV, 16'd100, 16'd7);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid",  {31'd0, bus.rsp_valid}, 32'd0);
        check("mid_rst_busy",   {31'd0, busy}, 32'd0);
        check("mid_rst_alu_in", alu_in, 32'd0);
        check("mid_rst_ctrl",   32'(alu_control), 32'(ADD));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);
        stale = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            stale = stale | bus.rsp_valid;
        end
        check("post_rst_no_stale", {31'd0, stale}, 32'd0);
        check("div_zero_never_exposed", {31'd0, div_zero_exposed}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
